draw_fill: RTL and testbench

DRAW_FILL -- requirements
Module: draw_fill

---
 rtl/draw_fill.sv | 243 ++++++++++++++++++++++++
 tb/tb_draw_fill.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_fill.sv
// Rectangle fill engine: writes a solid 32-bit colour into a strided 2-D
// region through an AXI4 write-only master, one burst outstanding at a time.
module draw_fill #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
    parameter int unsigned C_MAX_BURST        = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    output logic [0:0]                      M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWLOCK,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic [3:0]                      M_AXI_AWQOS,
    output logic [0:0]                      M_AXI_AWUSER,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    input  logic [15:0]                     WRADDR,
    input  logic [3:0]                      BYTEEN,
    input  logic                            WREN,
    input  logic [31:0]                     WDATA,
    input  logic [15:0]                     RDADDR,
    input  logic                            RDEN,
    output logic [31:0]                     RDATA,
    output logic                            DRW_IRQ
);

    localparam int unsigned ADDR_W     = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned PPB        = C_M_AXI_DATA_WIDTH / 32;
    localparam int unsigned BPB        = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned BEAT_SHIFT = $clog2(BPB);
    localparam int unsigned PPB_SHIFT  = $clog2(PPB);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_NEXT, S_DONE} state_t;

    state_t state;

    logic              ctrl_irqen, st_done, st_err;
    logic [31:0]       dst_reg, stride_reg, size_reg, color_reg, rd_data_c;
    logic              busy_c, start_c, set_done_c, set_err_c;
    logic [ADDR_W-1:0] cur_addr, line_start, stride_q, nxt_addr_c;
    logic [15:0]       line_beats, rem_beats, lines_left, lb_c, nxt_rem_c;
    logic [7:0]        beat_cnt, nxt_len_c;
    logic [8:0]        burst_c;
    logic              line_end_c;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWSIZE  = 3'(BEAT_SHIFT);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_AWUSER  = '0;
    assign M_AXI_WSTRB   = '1;

    // Burst length minus one: bounded by line remainder, max burst and 4 KB page.
    function automatic logic [7:0] burst_len_f(input logic [11:0] addr_lo, input logic [15:0] rem);
        logic [12:0] to4k;
        logic [16:0] lim;
        to4k = 13'h1000 - {1'b0, addr_lo};
        lim  = 17'(to4k >> BEAT_SHIFT);
        if (17'(rem) < lim)         lim = 17'(rem);
        if (17'(C_MAX_BURST) < lim) lim = 17'(C_MAX_BURST);
        return 8'(lim - 17'd1);
    endfunction

    function automatic logic [31:0] merge_f(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    always_comb begin
        busy_c     = (state != S_IDLE);
        start_c    = WREN && (WRADDR == 16'h0000) && BYTEEN[0] && WDATA[0];
        set_done_c = (state == S_DONE);
        set_err_c  = (state == S_B) && M_AXI_BVALID && (M_AXI_BRESP != 2'b00);
        lb_c       = 16'(size_reg[15:0] >> PPB_SHIFT);
        burst_c    = {1'b0, M_AXI_AWLEN} + 9'd1;
        line_end_c = (rem_beats == 16'(burst_c));
        // Next burst start: snapshot on START, else advance within or past the line.
        if (state == S_IDLE) begin
            nxt_addr_c = ADDR_W'(dst_reg);
            nxt_rem_c  = lb_c;
        end else if (line_end_c) begin
            nxt_addr_c = line_start + stride_q;
            nxt_rem_c  = line_beats;
        end else begin
            nxt_addr_c = cur_addr + (ADDR_W'(burst_c) << BEAT_SHIFT);
            nxt_rem_c  = rem_beats - 16'(burst_c);
        end
        nxt_len_c = burst_len_f(nxt_addr_c[11:0], nxt_rem_c);
    end

    always_comb begin
        rd_data_c = 32'h0;
        case (RDADDR)
            16'h0000: rd_data_c = {30'h0, ctrl_irqen, 1'b0};
            16'h0004: rd_data_c = {29'h0, st_err, st_done, busy_c};
            16'h0008: rd_data_c = dst_reg;
            16'h000C: rd_data_c = stride_reg;
            16'h0010: rd_data_c = size_reg;
            16'h0014: rd_data_c = color_reg;
            default:  rd_data_c = 32'h0;
        endcase
    end

    // Register file, sticky status and interrupt.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ctrl_irqen <= 1'b0;
            st_done    <= 1'b0;
            st_err     <= 1'b0;
            dst_reg    <= 32'h0;
            stride_reg <= 32'h0;
            size_reg   <= 32'h0;
            color_reg  <= 32'h0;
            RDATA      <= 32'h0;
            DRW_IRQ    <= 1'b0;
        end else begin
            if (WREN && BYTEEN[0] && WRADDR == 16'h0000) ctrl_irqen <= WDATA[1];
            if (WREN && BYTEEN[0] && WRADDR == 16'h0004) begin
                if (WDATA[1]) st_done <= 1'b0;
                if (WDATA[2]) st_err  <= 1'b0;
            end
            if (set_done_c) st_done <= 1'b1;
            if (set_err_c)  st_err  <= 1'b1;
            if (WREN && WRADDR == 16'h0008) dst_reg    <= merge_f(dst_reg, WDATA, BYTEEN);
            if (WREN && WRADDR == 16'h000C) stride_reg <= merge_f(stride_reg, WDATA, BYTEEN);
            if (WREN && WRADDR == 16'h0010) size_reg   <= merge_f(size_reg, WDATA, BYTEEN);
            if (WREN && WRADDR == 16'h0014) color_reg  <= merge_f(color_reg, WDATA, BYTEEN);
            if (RDEN) RDATA <= rd_data_c;
            DRW_IRQ <= st_done & ctrl_irqen;
        end
    end

    // Burst sequencer.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= S_IDLE;
            cur_addr      <= '0;
            line_start    <= '0;
            stride_q      <= '0;
            line_beats    <= 16'h0;
            rem_beats     <= 16'h0;
            lines_left    <= 16'h0;
            beat_cnt      <= 8'h0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWLEN   <= 8'h0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_WLAST   <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_c) begin
                        if (size_reg[15:0] == 16'h0 || size_reg[31:16] == 16'h0) begin
                            state <= S_DONE;
                        end else begin
                            cur_addr      <= nxt_addr_c;
                            line_start    <= nxt_addr_c;
                            stride_q      <= ADDR_W'(stride_reg);
                            line_beats    <= lb_c;
                            rem_beats     <= lb_c;
                            lines_left    <= size_reg[31:16];
                            M_AXI_WDATA   <= {PPB{color_reg}};
                            M_AXI_AWADDR  <= nxt_addr_c;
                            M_AXI_AWLEN   <= nxt_len_c;
                            M_AXI_AWVALID <= 1'b1;
                            state         <= S_AW;
                        end
                    end
                end
                S_AW: begin
                    if (M_AXI_AWREADY) begin
                        M_AXI_AWVALID <= 1'b0;
                        M_AXI_WVALID  <= 1'b1;
                        M_AXI_WLAST   <= (M_AXI_AWLEN == 8'd0);
                        beat_cnt      <= 8'h0;
                        state         <= S_W;
                    end
                end
                S_W: begin
                    if (M_AXI_WREADY) begin
                        if (M_AXI_WLAST) begin
                            M_AXI_WVALID <= 1'b0;
                            M_AXI_WLAST  <= 1'b0;
                            M_AXI_BREADY <= 1'b1;
                            state        <= S_B;
                        end else begin
                            beat_cnt    <= beat_cnt + 8'd1;
                            M_AXI_WLAST <= (beat_cnt + 8'd1 == M_AXI_AWLEN);
                        end
                    end
                end
                S_B: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        state        <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (line_end_c && lines_left == 16'd1) begin
                        lines_left <= 16'h0;
                        state      <= S_DONE;
                    end else begin
                        if (line_end_c) begin
                            line_start <= nxt_addr_c;
                            lines_left <= lines_left - 16'd1;
                        end
                        cur_addr      <= nxt_addr_c;
                        rem_beats     <= nxt_rem_c;
                        M_AXI_AWADDR  <= nxt_addr_c;
                        M_AXI_AWLEN   <= nxt_len_c;
                        M_AXI_AWVALID <= 1'b1;
                        state         <= S_AW;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_fill.sv
// Directed bench for draw_fill with an AXI write-slave model that logs
// address bursts, checks beat data/WLAST and returns configurable responses.
module tb_draw_fill;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [0:0]        M_AXI_AWID, M_AXI_AWUSER;
    logic [ADDR_W-1:0] M_AXI_AWADDR;
    logic [7:0]        M_AXI_AWLEN;
    logic [2:0]        M_AXI_AWSIZE, M_AXI_AWPROT;
    logic [1:0]        M_AXI_AWBURST;
    logic              M_AXI_AWLOCK;
    logic [3:0]        M_AXI_AWCACHE, M_AXI_AWQOS;
    logic              M_AXI_AWVALID;
    logic              M_AXI_AWREADY = 1'b0;
    logic [DATA_W-1:0] M_AXI_WDATA;
    logic [DATA_W/8-1:0] M_AXI_WSTRB;
    logic              M_AXI_WLAST, M_AXI_WVALID;
    logic              M_AXI_WREADY = 1'b0;
    logic [1:0]        M_AXI_BRESP = 2'b00;
    logic              M_AXI_BVALID = 1'b0;
    logic              M_AXI_BREADY;
    logic [15:0]       WRADDR = 16'h0, RDADDR = 16'h0;
    logic [3:0]        BYTEEN = 4'h0;
    logic              WREN = 1'b0, RDEN = 1'b0;
    logic [31:0]       WDATA = 32'h0, RDATA;
    logic              DRW_IRQ;

    int checks = 0;
    int fails  = 0;

    // Slave model state
    logic [31:0] aw_addr_log [256];
    logic [7:0]  aw_len_log  [256];
    int          aw_cnt = 0, beat_total = 0, b_cnt = 0, mon_err = 0;
    int          cur_len = 0, cur_beats = 0;
    bit          in_burst = 0, b_pending = 0, b_hs = 0;
    bit          stall = 0;
    int          err_b_idx = -1;
    logic [31:0] color_exp = 32'h0;
    bit          irqen = 0;

    draw_fill #(.C_M_AXI_ADDR_WIDTH(ADDR_W), .C_M_AXI_DATA_WIDTH(DATA_W), .C_MAX_BURST(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
        .M_AXI_AWUSER(M_AXI_AWUSER), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
        .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA), .DRW_IRQ(DRW_IRQ)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave: decides readies at negedge; a handshake is recorded when it will occur at the next posedge.
    always @(negedge ACLK) begin
        if (ARESET) begin
            M_AXI_AWREADY = 1'b0;
            M_AXI_WREADY  = 1'b0;
            M_AXI_BVALID  = 1'b0;
            M_AXI_BRESP   = 2'b00;
            in_burst = 0; b_pending = 0; b_hs = 0;
        end else begin
            if (b_hs) begin
                M_AXI_BVALID = 1'b0;
                M_AXI_BRESP  = 2'b00;
                b_hs = 0;
            end
            if (b_pending && !M_AXI_BVALID && (!stall || $urandom_range(0, 2) == 0)) begin
                M_AXI_BVALID = 1'b1;
                M_AXI_BRESP  = (b_cnt == err_b_idx) ? 2'b10 : 2'b00;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                b_hs = 1; b_pending = 0; b_cnt++;
            end

            M_AXI_AWREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                if (in_burst || b_pending || b_hs) mon_err++;
                aw_addr_log[8'(aw_cnt)] = M_AXI_AWADDR;
                aw_len_log[8'(aw_cnt)]  = M_AXI_AWLEN;
                aw_cnt++;
                cur_len = int'(M_AXI_AWLEN);
                cur_beats = 0;
                in_burst = 1;
            end

            M_AXI_WREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (M_AXI_WVALID) begin
                if (!in_burst) mon_err++;
                if (M_AXI_WDATA !== {color_exp, color_exp}) mon_err++;
                if (M_AXI_WREADY) begin
                    if (M_AXI_WLAST !== (cur_beats == cur_len)) mon_err++;
                    cur_beats++;
                    beat_total++;
                    if (cur_beats > cur_len) begin
                        in_burst = 0;
                        b_pending = 1;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        WRADDR = a; WDATA = d; BYTEEN = be; WREN = 1'b1;
        @(negedge ACLK);
        WREN = 1'b0; BYTEEN = 4'h0;
    endtask

    task automatic reg_read(input logic [15:0] a, output logic [31:0] d);
        RDADDR = a; RDEN = 1'b1;
        @(negedge ACLK);
        RDEN = 1'b0;
        d = RDATA;
    endtask

    task automatic configure(input logic [31:0] dst, input logic [31:0] stride,
                             input logic [15:0] w, input logic [15:0] h, input logic [31:0] color);
        reg_write(16'h0008, dst, 4'hF);
        reg_write(16'h000C, stride, 4'hF);
        reg_write(16'h0010, {h, w}, 4'hF);
        reg_write(16'h0014, color, 4'hF);
        color_exp = color;
    endtask

    task automatic start_fill();
        reg_write(16'h0000, {30'h0, irqen, 1'b1}, 4'h1);
    endtask

    task automatic wait_idle();
        logic [31:0] st;
        bit ok = 0;
        for (int i = 0; i < 1000; i++) begin
            reg_read(16'h0004, st);
            if (!st[0]) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL wait_idle: BUSY still %0d after 1000 polls, required 0", st[0]);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        ARESET = 1'b1;
        tick(3);
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY, DRW_IRQ, RDATA} !== 37'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h required 0",
                     {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY, DRW_IRQ, RDATA});
        end
        checks++;
        if ({M_AXI_AWID, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWCACHE, M_AXI_AWLOCK, M_AXI_AWPROT,
             M_AXI_AWQOS, M_AXI_AWUSER, M_AXI_WSTRB} !==
            {1'b0, 3'd3, 2'b01, 4'b0011, 1'b0, 3'b000, 4'h0, 1'b0, 8'hFF}) begin
            fails++;
            $display("FAIL const_aw: got %h required %h",
                     {M_AXI_AWID, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWCACHE, M_AXI_AWLOCK,
                      M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER, M_AXI_WSTRB},
                     {1'b0, 3'd3, 2'b01, 4'b0011, 1'b0, 3'b000, 4'h0, 1'b0, 8'hFF});
        end
        ARESET = 1'b0;
        tick(1);
        reg_read(16'h0004, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_status: got %h required 0", d); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        reg_write(16'h0008, 32'hAABBCCDD, 4'hF);
        reg_write(16'h0008, 32'h11223344, 4'b0101);
        reg_read(16'h0008, d);
        checks++;
        if (d !== 32'hAA22CC44) begin fails++; $display("FAIL byteen_merge: got %h required aa22cc44", d); end
        reg_write(16'h0000, 32'h2, 4'h1);
        reg_read(16'h0000, d);
        checks++;
        if (d !== 32'h2) begin fails++; $display("FAIL ctrl_readback: got %h required 2", d); end
        reg_read(16'h0018, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL unmapped_read: got %h required 0", d); end
        RDADDR = 16'h0014;
        tick(2);
        checks++;
        if (RDATA !== 32'h0) begin fails++; $display("FAIL rdata_hold: got %h required 0", RDATA); end
        reg_write(16'h0000, 32'h0, 4'h1);
    endtask

    task automatic test_basic();
        logic [31:0] d;
        int b0 = aw_cnt, bt = beat_total, me = mon_err;
        irqen = 1;
        configure(32'h1000_0000, 32'h1000, 16'd8, 16'd2, 32'hFF00FF00);
        start_fill();
        wait_idle();
        checks++;
        if (aw_cnt - b0 !== 2) begin fails++; $display("FAIL basic_aw_count: got %0d required 2", aw_cnt - b0); end
        checks++;
        if ({aw_addr_log[8'(b0)], aw_len_log[8'(b0)], aw_addr_log[8'(b0 + 1)], aw_len_log[8'(b0 + 1)]} !==
            {32'h1000_0000, 8'd3, 32'h1000_1000, 8'd3}) begin
            fails++;
            $display("FAIL basic_aw: got %h/%0d %h/%0d required 10000000/3 10001000/3",
                     aw_addr_log[8'(b0)], aw_len_log[8'(b0)], aw_addr_log[8'(b0 + 1)], aw_len_log[8'(b0 + 1)]);
        end
        checks++;
        if (beat_total - bt !== 8 || mon_err !== me) begin
            fails++;
            $display("FAIL basic_beats: beats %0d protocol_errs %0d required 8 and 0", beat_total - bt, mon_err - me);
        end
        reg_read(16'h0004, d);
        checks++;
        if (d !== 32'h2) begin fails++; $display("FAIL basic_status: got %h required 2", d); end
        tick(1);
        checks++;
        if (DRW_IRQ !== 1'b1) begin fails++; $display("FAIL basic_irq: got %b required 1", DRW_IRQ); end
        reg_write(16'h0004, 32'h2, 4'h1);
        tick(2);
        reg_read(16'h0004, d);
        checks++;
        if ({d, DRW_IRQ} !== 33'h0) begin fails++; $display("FAIL done_clear: status %h irq %b required 0 0", d, DRW_IRQ); end
    endtask

    task automatic test_burst_split();
        int b0 = aw_cnt, bt = beat_total;
        configure(32'h2000_0000, 32'h100, 16'd40, 16'd1, 32'h12345678);
        start_fill();
        wait_idle();
        checks++;
        if (aw_cnt - b0 !== 2 || beat_total - bt !== 20 ||
            {aw_addr_log[8'(b0)], aw_len_log[8'(b0)], aw_addr_log[8'(b0 + 1)], aw_len_log[8'(b0 + 1)]} !==
            {32'h2000_0000, 8'd15, 32'h2000_0080, 8'd3}) begin
            fails++;
            $display("FAIL max_burst_split: n=%0d beats=%0d %h/%0d %h/%0d required 2 20 20000000/15 20000080/3",
                     aw_cnt - b0, beat_total - bt, aw_addr_log[8'(b0)], aw_len_log[8'(b0)],
                     aw_addr_log[8'(b0 + 1)], aw_len_log[8'(b0 + 1)]);
        end
        reg_write(16'h0004, 32'h6, 4'h1);
    endtask

    task automatic test_4k_boundary();
        int b0 = aw_cnt;
        configure(32'h1000_0FE0, 32'h1000, 16'd16, 16'd1, 32'h0BADF00D);
        start_fill();
        wait_idle();
        checks++;
        if (aw_cnt - b0 !== 2 ||
            {aw_addr_log[8'(b0)], aw_len_log[8'(b0)], aw_addr_log[8'(b0 + 1)], aw_len_log[8'(b0 + 1)]} !==
            {32'h1000_0FE0, 8'd3, 32'h1000_1000, 8'd3}) begin
            fails++;
            $display("FAIL split_4k: n=%0d %h/%0d %h/%0d required 2 10000fe0/3 10001000/3",
                     aw_cnt - b0, aw_addr_log[8'(b0)], aw_len_log[8'(b0)],
                     aw_addr_log[8'(b0 + 1)], aw_len_log[8'(b0 + 1)]);
        end
        reg_write(16'h0004, 32'h6, 4'h1);
    endtask

    task automatic test_stall_err();
        logic [31:0] d;
        int b0 = aw_cnt, bt = beat_total, me = mon_err;
        stall = 1;
        err_b_idx = b_cnt + 1;
        configure(32'h3000_0000, 32'h2000, 16'd40, 16'd2, 32'hA5A50F0F);
        start_fill();
        wait_idle();
        checks++;
        if (aw_cnt - b0 !== 4 || beat_total - bt !== 40 || mon_err !== me) begin
            fails++;
            $display("FAIL stall_counts: bursts %0d beats %0d protocol_errs %0d required 4 40 0",
                     aw_cnt - b0, beat_total - bt, mon_err - me);
        end
        checks++;
        if ({aw_addr_log[8'(b0 + 2)], aw_len_log[8'(b0 + 2)], aw_addr_log[8'(b0 + 3)], aw_len_log[8'(b0 + 3)]} !==
            {32'h3000_2000, 8'd15, 32'h3000_2080, 8'd3}) begin
            fails++;
            $display("FAIL stall_line2: got %h/%0d %h/%0d required 30002000/15 30002080/3",
                     aw_addr_log[8'(b0 + 2)], aw_len_log[8'(b0 + 2)], aw_addr_log[8'(b0 + 3)], aw_len_log[8'(b0 + 3)]);
        end
        reg_read(16'h0004, d);
        checks++;
        if (d !== 32'h6) begin fails++; $display("FAIL err_status: got %h required 6", d); end
        stall = 0;
        err_b_idx = -1;
        reg_write(16'h0004, 32'h6, 4'h1);
    endtask

    task automatic test_zero_size();
        logic [31:0] d1, d2;
        int b0 = aw_cnt;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) configure(32'h5000_0000, 32'h1000, 16'd8, 16'd0, 32'h1);
            else        configure(32'h5000_0000, 32'h1000, 16'd0, 16'd3, 32'h1);
            start_fill();
            reg_read(16'h0004, d1);
            reg_read(16'h0004, d2);
            checks++;
            if (d1 !== 32'h1 || d2 !== 32'h2) begin
                fails++;
                $display("FAIL zero_size_%0d: status %h then %h required 1 then 2", k, d1, d2);
            end
            reg_write(16'h0004, 32'h6, 4'h1);
        end
        checks++;
        if (aw_cnt !== b0) begin fails++; $display("FAIL zero_size_aw: got %0d bursts required 0", aw_cnt - b0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int b0 = aw_cnt, bt = beat_total;
        stall = 1;
        configure(32'h4000_0000, 32'h1000, 16'd40, 16'd2, 32'h5A5A5A5A);
        start_fill();
        tick(3);
        reg_read(16'h0004, d);
        checks++;
        if (d[0] !== 1'b1) begin fails++; $display("FAIL busy_flag: got %b required 1", d[0]); end
        reg_write(16'h0008, 32'h7000_0000, 4'hF);
        start_fill();
        wait_idle();
        tick(20);
        checks++;
        if (aw_cnt - b0 !== 4 || beat_total - bt !== 40 ||
            {aw_addr_log[8'(b0)], aw_addr_log[8'(b0 + 3)], aw_len_log[8'(b0 + 3)]} !==
            {32'h4000_0000, 32'h4000_1080, 8'd3}) begin
            fails++;
            $display("FAIL start_while_busy: n=%0d beats=%0d first %h last %h/%0d required 4 40 40000000 40001080/3",
                     aw_cnt - b0, beat_total - bt, aw_addr_log[8'(b0)], aw_addr_log[8'(b0 + 3)], aw_len_log[8'(b0 + 3)]);
        end
        reg_read(16'h0008, d);
        checks++;
        if (d !== 32'h7000_0000) begin fails++; $display("FAIL busy_regwrite: got %h required 70000000", d); end
        stall = 0;
        reg_write(16'h0004, 32'h6, 4'h1);
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] d;
        int b0;
        bit seen = 0;
        configure(32'h6000_0000, 32'h1000, 16'd40, 16'd4, 32'hCAFEBABE);
        start_fill();
        for (int i = 0; i < 50; i++) begin
            if (M_AXI_WVALID) begin seen = 1; break; end
            @(negedge ACLK);
        end
        checks++;
        if (!seen) begin fails++; $display("FAIL reach_w: WVALID %b after 50 cycles, required 1", M_AXI_WVALID); end
        ARESET = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY, DRW_IRQ, RDATA} !== 37'h0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got %h required 0",
                     {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY, DRW_IRQ, RDATA});
        end
        ARESET = 1'b0;
        tick(1);
        reg_read(16'h0004, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL mid_reset_status: got %h required 0", d); end
        irqen = 0;
        b0 = aw_cnt;
        configure(32'h1000_0000, 32'h1000, 16'd8, 16'd2, 32'h13572468);
        start_fill();
        wait_idle();
        checks++;
        if (aw_cnt - b0 !== 2 || aw_addr_log[8'(b0 + 1)] !== 32'h1000_1000) begin
            fails++;
            $display("FAIL post_reset_fill: n=%0d second %h required 2 10001000", aw_cnt - b0, aw_addr_log[8'(b0 + 1)]);
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_basic();
        test_burst_split();
        test_4k_boundary();
        test_stall_err();
        test_zero_size();
        test_back_to_back();
        test_reset_mid_burst();
        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
